hazard_control_unit: RTL and testbench

Pipeline sequencing controller for the execute stage. It detects load-use hazards between ID and EX and inserts the required bubble. It sequences multi-cycle multiply/divide operations in EX by freezing the front of the pipeline until the result is ready. It squashes the younger instructions in IF/ID and ID/EX when EX resolves a taken branch.

---
 rtl/hazard_control_unit_pkg.sv | 7 +
 rtl/hazard_control_unit_load_use_detector.sv | 17 +
 rtl/hazard_control_unit.sv | 80 ++++++++
 tb/tb_hazard_control_unit.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/hazard_control_unit_pkg.sv
// hazard_control_unit_pkg: shared pipeline sequencing types and constants.
package hazard_control_unit_pkg;
   typedef enum logic {ST_IDLE = 1'b0, ST_MULDIV = 1'b1} state_t;
   localparam int REG_ZERO = 0;
   localparam int MUL_CYCLES_DEF = 4;
   localparam int DIV_CYCLES_DEF = 32;
endpackage

// File: rtl/hazard_control_unit_load_use_detector.sv
// load_use_detector: flags an ID instruction that reads the register a load in EX is writing.
module load_use_detector
   import hazard_control_unit_pkg::*;
#(
   parameter int REG_ADDR_W = 5
) (
   input  logic                  id_valid,
   input  logic                  id_ex_mem_read,
   input  logic [REG_ADDR_W-1:0] id_ex_rt,
   input  logic [REG_ADDR_W-1:0] if_id_rs,
   input  logic [REG_ADDR_W-1:0] if_id_rt,
   output logic                  hazard
);
   // $0 is hardwired, so a load targeting it can never create a dependency
   assign hazard = id_valid && id_ex_mem_read && (id_ex_rt != REG_ADDR_W'(REG_ZERO)) &&
                   (id_ex_rt == if_id_rs || id_ex_rt == if_id_rt);
endmodule

// File: rtl/hazard_control_unit.sv
// hazard_control_unit: load-use bubbles, mul/div front-end freeze and branch squash for EX.
module hazard_control_unit
   import hazard_control_unit_pkg::*;
#(
   parameter int REG_ADDR_W = 5,
   parameter int MUL_CYCLES = MUL_CYCLES_DEF,
   parameter int DIV_CYCLES = DIV_CYCLES_DEF,
   parameter int CNT_W      = 6,
   parameter int PERF_W     = 16
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  id_valid,
   input  logic [REG_ADDR_W-1:0] if_id_rs,
   input  logic [REG_ADDR_W-1:0] if_id_rt,
   input  logic                  id_ex_mem_read,
   input  logic [REG_ADDR_W-1:0] id_ex_rt,
   input  logic                  ex_muldiv_start,
   input  logic                  ex_muldiv_is_div,
   input  logic                  branch_taken,
   output logic                  pc_write,
   output logic                  if_id_write,
   output logic                  if_id_flush,
   output logic                  id_ex_flush,
   output logic                  ex_hold,
   output logic                  muldiv_busy,
   output logic                  muldiv_done,
   output logic [PERF_W-1:0]     stall_cycles
);
   state_t           state;
   logic [CNT_W-1:0] count;
   logic             hazard;
   logic             in_md;
   logic             md_run;
   logic             br;
   logic             st;
   logic             lu;

   load_use_detector #(.REG_ADDR_W(REG_ADDR_W)) u_lud (
      .id_valid      (id_valid),
      .id_ex_mem_read(id_ex_mem_read),
      .id_ex_rt      (id_ex_rt),
      .if_id_rs      (if_id_rs),
      .if_id_rt      (if_id_rt),
      .hazard        (hazard)
   );

   // The final MULDIV cycle behaves like IDLE for load-use only; branch/start cannot occur there
   assign in_md  = (state == ST_MULDIV);
   assign md_run = in_md && (count != '0);
   assign br     = !in_md && branch_taken;
   assign st     = !in_md && !branch_taken && ex_muldiv_start;
   assign lu     = hazard && !md_run && !br && !st;

   assign ex_hold     = st || md_run;
   assign pc_write    = !(st || md_run || lu);
   assign if_id_write = pc_write;
   assign if_id_flush = br;
   assign id_ex_flush = br || lu;
   assign muldiv_busy = in_md;
   assign muldiv_done = in_md && (count == '0);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state        <= ST_IDLE;
         count        <= '0;
         stall_cycles <= '0;
      end else begin
         if (st) begin
            state <= ST_MULDIV;
            count <= ex_muldiv_is_div ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MUL_CYCLES - 1);
         end else if (md_run)
            count <= count - 1'b1;
         else if (in_md)
            state <= ST_IDLE;
         if (!pc_write && stall_cycles != '1)
            stall_cycles <= stall_cycles + 1'b1;
      end
   end
endmodule

// File: tb/tb_hazard_control_unit.sv
// tb_hazard_control_unit: table-driven and sequence checks with an expected-output queue.
module tb_hazard_control_unit;
   localparam int PW = 4;

   typedef struct packed {
      logic       v;
      logic [4:0] rs;
      logic [4:0] rt;
      logic       mr;
      logic [4:0] ert;
      logic       st;
      logic       dv;
      logic       br;
   } in_t;

   typedef struct {
      string      name;
      in_t        i;
      logic [6:0] e;
   } vec_t;

   // expected outputs: {pc_write, if_id_write, if_id_flush, id_ex_flush, ex_hold, busy, done}
   localparam logic [6:0] O_RUN  = 7'b1100000;
   localparam logic [6:0] O_LU   = 7'b0001000;
   localparam logic [6:0] O_BR   = 7'b1111000;
   localparam logic [6:0] O_ST   = 7'b0000100;
   localparam logic [6:0] O_MD   = 7'b0000110;
   localparam logic [6:0] O_DN   = 7'b1100011;
   localparam logic [6:0] O_DNLU = 7'b0001011;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          id_valid, id_ex_mem_read, ex_muldiv_start, ex_muldiv_is_div, branch_taken;
   logic [4:0]    if_id_rs, if_id_rt, id_ex_rt;
   logic          pc_write, if_id_write, if_id_flush, id_ex_flush, ex_hold, muldiv_busy, muldiv_done;
   logic [PW-1:0] stall_cycles;

   int            checks = 0;
   int            errors = 0;
   logic [PW-1:0] exp_sc = '0;
   logic [6:0]    sb[$];

   hazard_control_unit #(.PERF_W(PW)) dut (
      .clock           (clock),
      .reset           (reset),
      .id_valid        (id_valid),
      .if_id_rs        (if_id_rs),
      .if_id_rt        (if_id_rt),
      .id_ex_mem_read  (id_ex_mem_read),
      .id_ex_rt        (id_ex_rt),
      .ex_muldiv_start (ex_muldiv_start),
      .ex_muldiv_is_div(ex_muldiv_is_div),
      .branch_taken    (branch_taken),
      .pc_write        (pc_write),
      .if_id_write     (if_id_write),
      .if_id_flush     (if_id_flush),
      .id_ex_flush     (id_ex_flush),
      .ex_hold         (ex_hold),
      .muldiv_busy     (muldiv_busy),
      .muldiv_done     (muldiv_done),
      .stall_cycles    (stall_cycles)
   );

   always #5 clock = ~clock;

   function automatic in_t mk(logic v, logic [4:0] rs, logic [4:0] rt, logic mr,
                              logic [4:0] ert, logic st, logic dv, logic br);
      return '{v: v, rs: rs, rt: rt, mr: mr, ert: ert, st: st, dv: dv, br: br};
   endfunction

   task automatic drive(input in_t i);
      id_valid         = i.v;
      if_id_rs         = i.rs;
      if_id_rt         = i.rt;
      id_ex_mem_read   = i.mr;
      id_ex_rt         = i.ert;
      ex_muldiv_start  = i.st;
      ex_muldiv_is_div = i.dv;
      branch_taken     = i.br;
   endtask

   task automatic check(input string name);
      logic [6:0] e, g;
      g = {pc_write, if_id_write, if_id_flush, id_ex_flush, ex_hold, muldiv_busy, muldiv_done};
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $display("FAIL %s scoreboard empty, got %b", name, g);
      end else begin
         e = sb.pop_front();
         if (g !== e) begin
            errors++;
            $display("FAIL %s outputs got %b want %b", name, g, e);
         end
      end
      checks++;
      if (stall_cycles !== exp_sc) begin
         errors++;
         $display("FAIL %s stall_cycles got %0d want %0d", name, stall_cycles, exp_sc);
      end
   endtask

   // drive one cycle, check mid-cycle, then advance the stall model across the edge
   task automatic step(input string name, input in_t i, input logic [6:0] e);
      drive(i);
      sb.push_back(e);
      @(negedge clock);
      check(name);
      if (!e[6] && exp_sc != '1) exp_sc = exp_sc + 1'b1;
      @(posedge clock);
      #1;
   endtask

   in_t  idle, haz;
   vec_t tbl[9];

   initial begin
      idle = mk(0, 0, 0, 0, 0, 0, 0, 0);
      haz  = mk(1, 8, 3, 1, 8, 0, 0, 0);
      tbl[0] = '{"nop",        idle,                         O_RUN};
      tbl[1] = '{"lu_rs",      haz,                          O_LU};
      tbl[2] = '{"lu_rt",      mk(1, 1, 9, 1, 9, 0, 0, 0),   O_LU};
      tbl[3] = '{"load_r0",    mk(1, 0, 0, 1, 0, 0, 0, 0),   O_RUN};
      tbl[4] = '{"id_invalid", mk(0, 8, 8, 1, 8, 0, 0, 0),   O_RUN};
      tbl[5] = '{"not_load",   mk(1, 8, 8, 0, 8, 0, 0, 0),   O_RUN};
      tbl[6] = '{"br_haz",     mk(1, 8, 3, 1, 8, 0, 0, 1),   O_BR};
      tbl[7] = '{"br_only",    mk(0, 0, 0, 0, 0, 0, 0, 1),   O_BR};
      tbl[8] = '{"no_match",   mk(1, 7, 6, 1, 8, 0, 0, 0),   O_RUN};

      drive(idle);
      #2;
      sb.push_back(O_RUN);
      check("in_reset");
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1;

      foreach (tbl[k]) step(tbl[k].name, tbl[k].i, tbl[k].e);

      // multiply; branch and hazard inside the sequence are ignored
      step("mul_start", mk(0, 0, 0, 0, 0, 1, 0, 0), O_ST);
      step("mul_c2", idle, O_MD);
      step("mul_c3_br", mk(1, 8, 3, 1, 8, 1, 0, 1), O_MD);
      step("mul_c4", idle, O_MD);
      step("mul_done", idle, O_DN);
      step("mul_after", idle, O_RUN);

      // hazard coincident with the done cycle still bubbles
      step("mul2_start", mk(0, 0, 0, 0, 0, 1, 0, 0), O_ST);
      for (int c = 2; c <= 4; c++) step("mul2_md", idle, O_MD);
      step("mul2_done_lu", haz, O_DNLU);
      step("mul2_after", idle, O_RUN);

      // divide: 32 stall cycles, done in cycle 33
      step("div_start", mk(0, 0, 0, 0, 0, 1, 1, 0), O_ST);
      for (int c = 2; c <= 32; c++) step("div_md", idle, O_MD);
      step("div_done", idle, O_DN);
      step("div_after", idle, O_RUN);

      // reset while the divide counter sits at 10
      step("rdiv_start", mk(0, 0, 0, 0, 0, 1, 1, 0), O_ST);
      for (int c = 2; c <= 22; c++) step("rdiv_md", idle, O_MD);
      reset = 1'b0;
      exp_sc = '0;
      #1;
      sb.push_back(O_RUN);
      check("rdiv_async");
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1;
      for (int c = 0; c < 35; c++) step("rdiv_post", idle, O_RUN);

      // continuous load-use stall drives the 4-bit counter into saturation
      for (int c = 0; c < 20; c++) step("sat_lu", haz, O_LU);
      step("sat_end", idle, O_RUN);
      checks++;
      if (stall_cycles !== 4'hF) begin
         errors++;
         $display("FAIL sat_final stall_cycles got %0d want 15", stall_cycles);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
